// File: rtl/tx_stream_framer.sv
// tx_stream_framer
//   Turns a raw sample stream into framed packets for the TX control path.
//   A burst is started by a settings-bus CMD write. Samples pass straight
//   through with zero latency; the block only adds packet boundaries
//   (o_tlast) and a per-packet header on o_tuser.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
//   both high. valid never depends on ready. In RUN the block is a wire:
//   o_tvalid = i_tvalid and i_tready = o_tready. In IDLE both are held low.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   clear                synchronous abort, also zeroes the sequence number
//   sid                  {src_sid, dst_sid} copied into every header
//   set_stb/addr/data    settings bus (SPP, TIME_HI, TIME_LO, CMD)
//   i_tdata/tvalid/tready  raw sample input
//   o_tdata/tlast/tvalid/tready/tuser  framed packet output, header on tuser
//   busy                 high while a burst is running
//   cmd_dropped          one-cycle pulse for every ignored CMD write
//   state_dbg            current FSM state (0 = IDLE, 1 = RUN)
module tx_stream_framer #(
  parameter logic [7:0] SR_FRAMER_SPP     = 8'd160,
  parameter logic [7:0] SR_FRAMER_TIME_HI = 8'd161,
  parameter logic [7:0] SR_FRAMER_TIME_LO = 8'd162,
  parameter logic [7:0] SR_FRAMER_CMD     = 8'd163
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [31:0]  sid,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [31:0]  i_tdata,
  input  logic         i_tvalid,
  output logic         i_tready,
  output logic [31:0]  o_tdata,
  output logic         o_tlast,
  output logic         o_tvalid,
  input  logic         o_tready,
  output logic [127:0] o_tuser,
  output logic         busy,
  output logic         cmd_dropped,
  output logic         state_dbg
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [13:0] SPP_MAX = 14'd16379;

  state_t state, state_n;

  // Reset release is re-timed to clk; commands wait until it has settled.
  logic [1:0] rst_sync;
  logic       rst_ok;

  logic [15:0] spp_reg;
  logic [31:0] time_hi;
  logic [31:0] time_lo;

  // Burst context, captured when a CMD is accepted.
  logic [13:0] b_spp;
  logic [63:0] b_time;
  logic [27:0] remaining;

  // Current packet context; held constant for every beat of the packet.
  logic [13:0] pkt_samps;
  logic [13:0] beat_cnt;
  logic        pkt_has_time;
  logic        pkt_eob;
  logic [11:0] seqnum;
  logic        drop_q;

  logic        is_cmd, cmd_accept, run, xfer, pkt_last, burst_last;
  logic [27:0] cmd_num, rem_after;
  logic [13:0] eff_spp, first_samps, next_samps;
  logic        first_eob, next_eob;
  logic [15:0] byte_len;

  assign rst_ok     = rst_sync[1];
  assign is_cmd     = set_stb && (set_addr == SR_FRAMER_CMD);
  assign cmd_num    = set_data[27:0];
  assign cmd_accept = is_cmd && (state == S_IDLE) && (cmd_num != 28'd0) && !clear && rst_ok;
  assign run        = (state == S_RUN);
  assign xfer       = run && i_tvalid && o_tready;
  assign pkt_last   = (beat_cnt == pkt_samps - 14'd1);
  assign burst_last = (remaining == 28'd1);
  assign rem_after  = remaining - 28'd1;

  assign eff_spp = (spp_reg == 16'd0)            ? 14'd1   :
                   (spp_reg > {2'b00, SPP_MAX})  ? SPP_MAX : spp_reg[13:0];

  // Packet size is min(SPP, samples left); the packet that fits the rest
  // of the burst is the end-of-burst packet.
  assign first_samps = (cmd_num < {14'd0, eff_spp}) ? cmd_num[13:0] : eff_spp;
  assign first_eob   = (cmd_num <= {14'd0, eff_spp});
  assign next_samps  = (rem_after < {14'd0, b_spp}) ? rem_after[13:0] : b_spp;
  assign next_eob    = (rem_after <= {14'd0, b_spp});

  assign byte_len = {pkt_samps, 2'b00} + (pkt_has_time ? 16'd16 : 16'd8);

  assign i_tready    = run && o_tready;
  assign o_tvalid    = run && i_tvalid;
  assign o_tdata     = run ? i_tdata : 32'd0;
  assign o_tlast     = run && pkt_last;
  assign o_tuser     = run ? {2'b00, pkt_has_time, pkt_eob, seqnum, byte_len, sid,
                              (pkt_has_time ? b_time : 64'd0)} : 128'd0;
  assign busy        = run;
  assign cmd_dropped = drop_q;
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (cmd_accept) state_n = S_RUN;
      S_RUN:   if (clear || (xfer && burst_last)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Settings registers: clear leaves them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spp_reg <= 16'd0;
      time_hi <= 32'd0;
      time_lo <= 32'd0;
    end else if (set_stb) begin
      if (set_addr == SR_FRAMER_SPP)     spp_reg <= set_data[15:0];
      if (set_addr == SR_FRAMER_TIME_HI) time_hi <= set_data;
      if (set_addr == SR_FRAMER_TIME_LO) time_lo <= set_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q       <= 1'b0;
      b_spp        <= 14'd0;
      b_time       <= 64'd0;
      remaining    <= 28'd0;
      pkt_samps    <= 14'd0;
      beat_cnt     <= 14'd0;
      pkt_has_time <= 1'b0;
      pkt_eob      <= 1'b0;
      seqnum       <= 12'd0;
    end else begin
      drop_q <= is_cmd && !cmd_accept;
      if (clear) begin
        seqnum   <= 12'd0;
        beat_cnt <= 14'd0;
      end else if (cmd_accept) begin
        b_spp        <= eff_spp;
        b_time       <= {time_hi, time_lo};
        remaining    <= cmd_num;
        pkt_samps    <= first_samps;
        pkt_eob      <= first_eob;
        pkt_has_time <= set_data[31];
        beat_cnt     <= 14'd0;
      end else if (xfer) begin
        remaining <= rem_after;
        if (pkt_last) begin
          beat_cnt     <= 14'd0;
          seqnum       <= seqnum + 12'd1;
          pkt_samps    <= next_samps;
          pkt_eob      <= next_eob;
          pkt_has_time <= 1'b0;
        end else begin
          beat_cnt <= beat_cnt + 14'd1;
        end
      end
    end
  end

endmodule

// File: doc/tx_stream_framer.md
TX_STREAM_FRAMER -- requirements
Module: tx_stream_framer

Interface
REQ-001 Parameter SR_FRAMER_SPP, default 8'd160: settings address of samples-per-packet register (16 bits).
REQ-002 Parameter SR_FRAMER_TIME_HI, default 8'd161: settings address of burst start time [63:32].
REQ-003 Parameter SR_FRAMER_TIME_LO, default 8'd162: settings address of burst start time [31:0].
REQ-004 Parameter SR_FRAMER_CMD, default 8'd163: settings address of burst command; a write starts a burst.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  synchronous abort; also clears the sequence number.
REQ-008 sid  in  32  {src_sid, dst_sid} placed in every header.
REQ-009 set_stb / set_addr / set_data  in  1/8/32  settings bus.
REQ-010 i_tdata / i_tvalid / i_tready  in/in/out  32/1/1  raw sample stream (one sample per beat, no framing).
REQ-011 o_tdata / o_tlast / o_tvalid / o_tready / o_tuser  out/out/out/in/out  32/1/1/1/128  framed packet stream into the TX control path.
REQ-012 busy  out  1  high from the accepted CMD until the last beat of the burst.
REQ-013 cmd_dropped  out  1  one-cycle pulse when a CMD write is ignored.

Function
REQ-014 CMD format: [31] timed, [27:0] num_samps; bits [30:28] ignored.
REQ-015 States: IDLE, RUN; a CMD write in IDLE with num_samps != 0 -> RUN on the next cycle.
REQ-016 A CMD write with num_samps == 0, or any CMD write while in RUN, SHALL be ignored and SHALL pulse cmd_dropped.
REQ-017 SPP, TIME_HI and TIME_LO are latched into the burst context on CMD acceptance; later writes affect only the next burst.
REQ-018 Effective SPP: 0 -> 1; values > 16379 -> 16379.
REQ-019 In IDLE: i_tready = 0 and o_tvalid = 0.
REQ-020 In RUN: o_tdata = i_tdata, o_tvalid = i_tvalid, i_tready = o_tready; the path has zero latency and no storage.
REQ-021 A beat transfers when o_tvalid && o_tready; only transferred beats advance the counters.
REQ-022 Packet sample count = min(effective SPP, samples remaining in burst).
REQ-023 o_tlast = 1 on the final beat of each packet.
REQ-024 After the final beat of the burst, the block SHALL return to IDLE and drop busy on the following cycle.
REQ-025 o_tuser[127:126] = 2'b00 (data packet).
REQ-026 o_tuser[125] has_time = 1 only on the first packet of a timed burst.
REQ-027 o_tuser[124] eob = 1 only on the last packet of the burst.
REQ-028 o_tuser[123:112] = 12-bit seqnum; increments after each packet's last beat and wraps 4095 -> 0 without a gap.
REQ-029 o_tuser[111:96] = byte length = 4 * packet samples + (has_time ? 16 : 8).
REQ-030 o_tuser[95:64] = sid; o_tuser[63:0] = latched time when has_time, else 0.
REQ-031 o_tuser SHALL be valid and held constant on every beat of a packet.
REQ-032 The 28-bit remaining count SHALL NOT underflow; a burst of N samples emits exactly N beats.
REQ-033 clear SHALL force IDLE on the next cycle (a truncated packet is permitted) and set seqnum to 0.
REQ-034 A CMD write coincident with clear SHALL be dropped, and cmd_dropped SHALL pulse.
REQ-035 clear SHALL NOT alter the SPP or time registers.

Reset
REQ-036 reset_n low SHALL asynchronously force: state IDLE, busy = 0, cmd_dropped = 0, o_tvalid = 0, o_tlast = 0, i_tready = 0, seqnum = 0, SPP = 0, time = 0, o_tuser = 0.
REQ-037 Release of reset_n is synchronised to clk; the first CMD is accepted no earlier than the 2nd cycle after release.
REQ-038 Asserting reset_n mid-burst SHALL abort the packet with no further beats emitted.

Verification
REQ-039 SPP = 4, untimed CMD num_samps = 10, o_tready = 1 -> packets of 4/4/2 samples; lengths 24/24/16; seq 0/1/2; eob on the third packet only; tlast on beats 4, 8, 10.
REQ-040 Timed CMD with time 64'h1_0000_0000, SPP = 100, num_samps = 50 -> one packet; has_time = 1, eob = 1, length 216, o_tuser[63:0] = 64'h1_0000_0000.
REQ-041 Random o_tready/i_tvalid stalls over a 1000-sample burst with SPP = 7 -> 143 packets; output data equals input order with no duplication or loss.
REQ-042 4097 packets with SPP = 1 -> seqnum sequence ...4095, 0, 1 with no gap.
REQ-043 Second CMD issued during RUN, and a CMD with num_samps = 0 -> cmd_dropped pulses once for each; the ongoing burst is unaffected.
REQ-044 clear after 3 beats of a packet -> o_tvalid = 0 on the next cycle, busy = 0, next burst starts with seq 0.
